// File: rtl/dtc_dcw_sched.sv
// rtl/dtc_dcw_sched.sv - DTC control-word scheduler: loop word or stepped calibration sweep.
// Optional DTCSCHED_SLEW_EN: slew-limited hand-back from calibration code to loop word.
module dtc_dcw_sched #(
  parameter int DTC_L      = 12,
  parameter int SETTLE_CYC = 4,
  parameter int MEAS_CYC   = 16,
  parameter int SLEW_STEP  = 64
) (
  input  logic             REFDTC,
  input  logic             sync_nrst,
  input  logic [DTC_L-1:0] LOOP_DCW,
  input  logic             CAL_START,
  input  logic             CAL_ABORT,
  input  logic [DTC_L-1:0] CAL_CODE0,
  input  logic [DTC_L-1:0] CAL_STEP,
  input  logic [7:0]       CAL_NPT,
  output logic [DTC_L-1:0] DCW_OUT,
  output logic             DCW_SRC,
  output logic             MEAS_EN,
  output logic [7:0]       CAL_IDX,
  output logic             CAL_BUSY,
  output logic             CAL_DONE
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_MEAS   = 3'd2,
    ST_STEP   = 3'd3,
    ST_RETURN = 3'd4
  } state_t;

  localparam int CNT_MAX = (SETTLE_CYC > MEAS_CYC) ? SETTLE_CYC : MEAS_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef DTCSCHED_SLEW_EN
  localparam int RET_STEP = SLEW_STEP;
`else
  // A step of the full code range makes the hand-back a single jump.
  localparam int RET_STEP = (1 << DTC_L) + 0 * SLEW_STEP;
`endif

  localparam logic [DTC_L:0]   RET_LIM    = (DTC_L+1)'(RET_STEP);
  localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] MEAS_END   = CNT_W'(MEAS_CYC - 1);

  state_t             state_q, state_d;
  logic [DTC_L-1:0]   code_q, code_d;
  logic [7:0]         idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ret_seen_q, ret_seen_d;
  logic [DTC_L-1:0]   dcw_out_q, dcw_out_d;
  logic               dcw_src_q, dcw_src_d;
  logic               meas_en_q, meas_en_d;
  logic               cal_busy_q, cal_busy_d;
  logic               cal_done_q, cal_done_d;

  logic [7:0]         npt_eff;
  logic               last_pt;
  logic [DTC_L:0]     code_sum;
  logic [DTC_L-1:0]   code_next;
  logic [DTC_L:0]     ret_gap;
  logic [DTC_L-1:0]   ret_dcw;

  always_comb begin
    npt_eff   = (CAL_NPT == 8'd0) ? 8'd1 : CAL_NPT;
    last_pt   = ({1'b0, idx_q} + 9'd1) >= {1'b0, npt_eff};
    code_sum  = {1'b0, code_q} + {1'b0, CAL_STEP};
    code_next = code_sum[DTC_L] ? {DTC_L{1'b1}} : code_sum[DTC_L-1:0];

    // Move the delivered word toward the loop word by at most RET_LIM.
    ret_gap = '0;
    ret_dcw = LOOP_DCW;
    if (LOOP_DCW >= dcw_out_q) begin
      ret_gap = {1'b0, LOOP_DCW} - {1'b0, dcw_out_q};
      if (ret_gap > RET_LIM) ret_dcw = dcw_out_q + RET_LIM[DTC_L-1:0];
    end else begin
      ret_gap = {1'b0, dcw_out_q} - {1'b0, LOOP_DCW};
      if (ret_gap > RET_LIM) ret_dcw = dcw_out_q - RET_LIM[DTC_L-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ret_seen_d = ret_seen_q;

    case (state_q)
      ST_IDLE: begin
        ret_seen_d = 1'b0;
        if (CAL_START && !CAL_ABORT) begin
          state_d = ST_SETTLE;
          code_d  = CAL_CODE0;
          idx_d   = 8'd0;
          cnt_d   = '0;
        end
      end
      ST_SETTLE: begin
        if (CAL_ABORT) begin
          state_d = ST_RETURN;
          cnt_d   = '0;
        end else if (cnt_q == SETTLE_END) begin
          state_d = ST_MEAS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_MEAS: begin
        if (CAL_ABORT) begin
          state_d = ST_RETURN;
          cnt_d   = '0;
        end else if (cnt_q == MEAS_END) begin
          state_d = ST_STEP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STEP: begin
        if (CAL_ABORT || last_pt) begin
          state_d = ST_RETURN;
        end else begin
          state_d = ST_SETTLE;
          code_d  = code_next;
          idx_d   = idx_q + 8'd1;
          cnt_d   = '0;
        end
      end
      ST_RETURN: begin
        ret_seen_d = 1'b1;
`ifdef DTCSCHED_SLEW_EN
        if (ret_dcw == LOOP_DCW) state_d = ST_IDLE;
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered images of the state being left at this edge.
    case (state_q)
      ST_IDLE:   dcw_out_d = LOOP_DCW;
      ST_RETURN: dcw_out_d = ret_dcw;
      default:   dcw_out_d = code_q;
    endcase
    dcw_src_d  = (state_q == ST_SETTLE) || (state_q == ST_MEAS) || (state_q == ST_STEP);
    meas_en_d  = (state_q == ST_MEAS) && !CAL_ABORT;
    cal_busy_d = (state_q != ST_IDLE);
    cal_done_d = (state_q == ST_RETURN) && !ret_seen_q;
  end

  always_ff @(posedge REFDTC or negedge sync_nrst) begin
    if (!sync_nrst) begin
      state_q    <= ST_IDLE;
      code_q     <= '0;
      idx_q      <= 8'd0;
      cnt_q      <= '0;
      ret_seen_q <= 1'b0;
      dcw_out_q  <= '0;
      dcw_src_q  <= 1'b0;
      meas_en_q  <= 1'b0;
      cal_busy_q <= 1'b0;
      cal_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      code_q     <= code_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      ret_seen_q <= ret_seen_d;
      dcw_out_q  <= dcw_out_d;
      dcw_src_q  <= dcw_src_d;
      meas_en_q  <= meas_en_d;
      cal_busy_q <= cal_busy_d;
      cal_done_q <= cal_done_d;
    end
  end

  assign DCW_OUT  = dcw_out_q;
  assign DCW_SRC  = dcw_src_q;
  assign MEAS_EN  = meas_en_q;
  assign CAL_IDX  = idx_q;
  assign CAL_BUSY = cal_busy_q;
  assign CAL_DONE = cal_done_q;

endmodule

// File: tb/tb_dtc_dcw_sched.sv
// tb/tb_dtc_dcw_sched.sv - self-checking bench for dtc_dcw_sched (default build).
module tb_dtc_dcw_sched;

  localparam int S = 4;
  localparam int M = 16;
  localparam int P = S + M + 1;

  logic        REFDTC;
  logic        sync_nrst;
  logic [11:0] LOOP_DCW;
  logic        CAL_START;
  logic        CAL_ABORT;
  logic [11:0] CAL_CODE0;
  logic [11:0] CAL_STEP;
  logic [7:0]  CAL_NPT;
  logic [11:0] DCW_OUT;
  logic        DCW_SRC;
  logic        MEAS_EN;
  logic [7:0]  CAL_IDX;
  logic        CAL_BUSY;
  logic        CAL_DONE;

  int errors = 0;
  int checks = 0;

  dtc_dcw_sched #(.DTC_L(12), .SETTLE_CYC(S), .MEAS_CYC(M), .SLEW_STEP(64)) dut (
    .REFDTC(REFDTC), .sync_nrst(sync_nrst), .LOOP_DCW(LOOP_DCW),
    .CAL_START(CAL_START), .CAL_ABORT(CAL_ABORT), .CAL_CODE0(CAL_CODE0),
    .CAL_STEP(CAL_STEP), .CAL_NPT(CAL_NPT), .DCW_OUT(DCW_OUT), .DCW_SRC(DCW_SRC),
    .MEAS_EN(MEAS_EN), .CAL_IDX(CAL_IDX), .CAL_BUSY(CAL_BUSY), .CAL_DONE(CAL_DONE)
  );

  initial REFDTC = 1'b0;
  always #5 REFDTC = ~REFDTC;

  // Sweep model: after start edge N, edge N+k (k>=1) belongs to point (k-1)/P,
  // phase (k-1)%P; measurement phases are S..S+M-1; point p drives code0+p*step saturated.
  task automatic run_sweep(input logic [11:0] c0, input logic [11:0] st, input logic [7:0] npt,
                           input int abort_k, input int restart_k, input string name);
    int n_eff, total, end_k, done_k, last_k, p, r, v;
    logic [11:0] loopw, exp_dcw;
    logic exp_src, exp_meas, exp_busy, exp_done;
    n_eff  = (npt == 8'd0) ? 1 : int'(npt);
    total  = n_eff * P;
    end_k  = (abort_k > 0) ? abort_k : total;
    done_k = end_k + 1;
    last_k = end_k + 2;
    loopw  = 12'($urandom);
    @(negedge REFDTC);
    CAL_CODE0 = c0; CAL_STEP = st; CAL_NPT = npt; LOOP_DCW = loopw;
    CAL_START = 1'b1; CAL_ABORT = 1'b0;
    for (int k = 1; k <= last_k; k++) begin
      @(negedge REFDTC);
      CAL_START = (k == restart_k);
      CAL_ABORT = (k == abort_k);
      @(posedge REFDTC);
      #1;
      p = 0; r = 0;
      if (k <= end_k) begin
        p = (k - 1) / P;
        r = (k - 1) % P;
        v = int'(c0) + p * int'(st);
        if (v > 4095) v = 4095;
        exp_dcw  = 12'(v);
        exp_src  = 1'b1;
        exp_meas = (r >= S) && (r < S + M) && (k != abort_k);
        exp_busy = 1'b1;
        exp_done = 1'b0;
      end else begin
        exp_dcw  = loopw;
        exp_src  = 1'b0;
        exp_meas = 1'b0;
        exp_busy = (k == done_k);
        exp_done = (k == done_k);
      end
      checks++;
      if (DCW_OUT !== exp_dcw) begin
        errors++; $display("FAIL %s dcw_out k=%0d got %h exp %h", name, k, DCW_OUT, exp_dcw);
      end
      checks++;
      if (DCW_SRC !== exp_src) begin
        errors++; $display("FAIL %s dcw_src k=%0d got %b exp %b", name, k, DCW_SRC, exp_src);
      end
      checks++;
      if (MEAS_EN !== exp_meas) begin
        errors++; $display("FAIL %s meas_en k=%0d got %b exp %b", name, k, MEAS_EN, exp_meas);
      end
      checks++;
      if (CAL_BUSY !== exp_busy) begin
        errors++; $display("FAIL %s cal_busy k=%0d got %b exp %b", name, k, CAL_BUSY, exp_busy);
      end
      checks++;
      if (CAL_DONE !== exp_done) begin
        errors++; $display("FAIL %s cal_done k=%0d got %b exp %b", name, k, CAL_DONE, exp_done);
      end
      if (k <= end_k && r == S) begin
        checks++;
        if (CAL_IDX !== 8'(p)) begin
          errors++; $display("FAIL %s cal_idx k=%0d got %0d exp %0d", name, k, CAL_IDX, p);
        end
      end
    end
    @(negedge REFDTC);
    CAL_START = 1'b0;
    CAL_ABORT = 1'b0;
  endtask

  task automatic test_reset();
    sync_nrst = 1'b0;
    LOOP_DCW = 12'h3C3; CAL_START = 1'b0; CAL_ABORT = 1'b0;
    CAL_CODE0 = '0; CAL_STEP = '0; CAL_NPT = '0;
    repeat (3) @(posedge REFDTC);
    #1;
    checks++;
    if ({DCW_OUT, DCW_SRC, MEAS_EN, CAL_IDX, CAL_BUSY, CAL_DONE} !== 24'd0) begin
      errors++;
      $display("FAIL reset outputs got dcw=%h src=%b meas=%b idx=%0d busy=%b done=%b exp all 0",
               DCW_OUT, DCW_SRC, MEAS_EN, CAL_IDX, CAL_BUSY, CAL_DONE);
    end
    @(negedge REFDTC);
    sync_nrst = 1'b1;
  endtask

  task automatic test_loop_passthrough();
    logic [11:0] w;
    for (int i = 0; i < 8; i++) begin
      w = (i == 0) ? 12'h5A3 : 12'($urandom);
      @(negedge REFDTC);
      LOOP_DCW = w;
      @(posedge REFDTC);
      #1;
      checks++;
      if (DCW_OUT !== w) begin
        errors++; $display("FAIL loop_pass dcw_out got %h exp %h", DCW_OUT, w);
      end
      checks++;
      if (DCW_SRC !== 1'b0 || CAL_BUSY !== 1'b0) begin
        errors++; $display("FAIL loop_pass src/busy got %b/%b exp 0/0", DCW_SRC, CAL_BUSY);
      end
    end
  endtask

  task automatic test_start_abort_idle();
    @(negedge REFDTC);
    CAL_CODE0 = 12'h700; CAL_STEP = 12'h010; CAL_NPT = 8'd2;
    CAL_START = 1'b1; CAL_ABORT = 1'b1;
    @(negedge REFDTC);
    CAL_START = 1'b0; CAL_ABORT = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge REFDTC);
      #1;
      checks++;
      if (CAL_BUSY !== 1'b0 || CAL_DONE !== 1'b0 || DCW_SRC !== 1'b0 || MEAS_EN !== 1'b0) begin
        errors++;
        $display("FAIL start_abort_idle busy=%b done=%b src=%b meas=%b exp all 0",
                 CAL_BUSY, CAL_DONE, DCW_SRC, MEAS_EN);
      end
    end
  endtask

  task automatic test_random();
    int npt, total, ab;
    for (int i = 0; i < 6; i++) begin
      npt   = $urandom_range(0, 3);
      total = ((npt == 0) ? 1 : npt) * P;
      ab    = ($urandom_range(0, 1) == 1) ? $urandom_range(1, total) : 0;
      run_sweep(12'($urandom), 12'($urandom_range(0, 1023)), 8'(npt), ab, 0, "random");
    end
  endtask

  task automatic test_reset_mid_sweep();
    @(negedge REFDTC);
    LOOP_DCW = 12'h2B4; CAL_CODE0 = 12'h600; CAL_STEP = 12'h040; CAL_NPT = 8'd3;
    CAL_START = 1'b1;
    @(negedge REFDTC);
    CAL_START = 1'b0;
    repeat (28) @(negedge REFDTC);
    #2 sync_nrst = 1'b0;
    #1;
    checks++;
    if ({DCW_OUT, DCW_SRC, MEAS_EN, CAL_IDX, CAL_BUSY, CAL_DONE} !== 24'd0) begin
      errors++;
      $display("FAIL reset_mid_sweep got dcw=%h src=%b meas=%b idx=%0d busy=%b done=%b exp all 0",
               DCW_OUT, DCW_SRC, MEAS_EN, CAL_IDX, CAL_BUSY, CAL_DONE);
    end
    @(negedge REFDTC);
    sync_nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge REFDTC);
      #1;
      checks++;
      if (CAL_DONE !== 1'b0 || CAL_BUSY !== 1'b0 || DCW_OUT !== 12'h2B4) begin
        errors++;
        $display("FAIL after_reset done=%b busy=%b dcw=%h exp 0/0/2b4", CAL_DONE, CAL_BUSY, DCW_OUT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_loop_passthrough();
    run_sweep(12'h100, 12'h080, 8'd3, 0, 0, "sweep_basic");
    run_sweep(12'hF80, 12'h100, 8'd3, 0, 0, "saturation");
    run_sweep(12'h100, 12'h080, 8'd3, P + S + 5, 0, "abort_meas");
    run_sweep(12'h300, 12'h010, 8'd0, 0, 10, "npt_zero");
    test_start_abort_idle();
    run_sweep(12'h020, 12'h020, 8'd2, 0, 0, "back_to_back_a");
    run_sweep(12'hE00, 12'h300, 8'd2, 0, 0, "back_to_back_b");
    test_random();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
